mvm_axis_result_rx: RTL

Receive-side endpoint for MVM result traffic leaving the NoC master port (AXIS_M_* of `mvm_top`). It accepts single-beat AXI-stream result packets and filters them by opcode in `TUSER[10:9]`. Accepted results are buffered in a FIFO and handed to the host through a valid/ready read port. It counts results against a host-programmed expected total and pulses `DONE` once every expected result has been received and drained.

---
 rtl/mvm_noc_pkg.sv | 26 ++
 rtl/mvm_rx_fifo.sv | 57 +++++
 rtl/mvm_axis_result_rx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mvm_noc_pkg.sv
// Shared NoC definitions for the MVM result receive path: opcodes,
// TUSER field bounds and the receiver state encoding.
package mvm_noc_pkg;

    localparam logic [1:0] OP_INSTR  = 2'b00;
    localparam logic [1:0] OP_RESULT = 2'b01;
    localparam logic [1:0] OP_INVEC  = 2'b10;
    localparam logic [1:0] OP_RFW    = 2'b11;

    localparam int TUSER_ADDR_LSB   = 0;
    localparam int TUSER_ADDR_MSB   = 8;
    localparam int TUSER_OP_LSB     = 9;
    localparam int TUSER_OP_MSB     = 10;
    localparam int TUSER_ROWSEL_LSB = 11;
    localparam int TUSER_ROWSEL_MSB = 74;

    localparam int ADDRW = TUSER_ADDR_MSB - TUSER_ADDR_LSB + 1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_COLLECT,
        RX_DRAIN,
        RX_FINISH
    } rx_state_t;

endpackage

// File: rtl/mvm_rx_fifo.sv
// First-word-fall-through FIFO; the head entry is visible on rd_data whenever
// the FIFO is non-empty, and reads as zero when empty.
module mvm_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Asynchronous head read keeps the next entry visible in the same cycle a pop completes.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mvm_axis_result_rx.sv
// Receives single-beat MVM result packets from the NoC, filters them by opcode,
// buffers them for the host and signals completion of an expected result count.
module mvm_axis_result_rx
    import mvm_noc_pkg::*;
#(
    parameter int         DATAW  = 512,
    parameter int         IDW    = 32,
    parameter int         DESTW  = 12,
    parameter int         USERW  = 75,
    parameter int         DEPTH  = 16,
    parameter int         CNTW   = 16,
    parameter logic [1:0] RES_OP = OP_RESULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [DATAW-1:0]  AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [IDW-1:0]    AXIS_S_TID,
    input  logic [DESTW-1:0]  AXIS_S_TDEST,
    input  logic [USERW-1:0]  AXIS_S_TUSER,
    input  logic              START,
    input  logic [CNTW-1:0]   EXPECT_CNT,
    output logic              RES_VALID,
    input  logic              RES_READY,
    output logic [DATAW-1:0]  RES_DATA,
    output logic [IDW-1:0]    RES_SRC,
    output logic [ADDRW-1:0]  RES_ADDR,
    output logic [CNTW-1:0]   RX_CNT,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR_OP,
    output logic              ERR_NOLAST
);

    localparam int ENTW    = DATAW + IDW + ADDRW;
    localparam int FIFO_AW = $clog2(DEPTH);

    rx_state_t         state_reg, state_next;
    logic [CNTW-1:0]   exp_reg, exp_next;
    logic [CNTW-1:0]   rx_cnt_reg, rx_cnt_next;
    logic              err_op_reg, err_op_next;
    logic              err_nolast_reg, err_nolast_next;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    logic [ENTW-1:0]   fifo_wr_data;
    logic [ENTW-1:0]   fifo_rd_data;

    logic              beat_hs;
    logic [1:0]        beat_op;
    logic              beat_good;

    // Destination and row-select bits are deliberately not stored.
    logic              unused_inputs;
    assign unused_inputs = ^{AXIS_S_TDEST, AXIS_S_TUSER[USERW-1:TUSER_ROWSEL_LSB]};

    assign beat_op   = AXIS_S_TUSER[TUSER_OP_MSB:TUSER_OP_LSB];
    assign beat_hs   = AXIS_S_TVALID && AXIS_S_TREADY;
    assign beat_good = AXIS_S_TLAST && (beat_op == RES_OP);

    // Ready never looks at TVALID; it also closes once the expected count is reached.
    assign AXIS_S_TREADY = (state_reg == RX_COLLECT) && !fifo_full && (rx_cnt_reg != exp_reg);

    assign fifo_push    = beat_hs && beat_good;
    assign fifo_pop     = RES_VALID && RES_READY;
    assign fifo_wr_data = {AXIS_S_TDATA, AXIS_S_TID, AXIS_S_TUSER[TUSER_ADDR_MSB:TUSER_ADDR_LSB]};

    mvm_rx_fifo #(
        .WIDTH (ENTW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .srst    (RST),
        .push    (fifo_push),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign RES_VALID                    = !fifo_empty;
    assign {RES_DATA, RES_SRC, RES_ADDR} = fifo_rd_data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= RX_IDLE;
            exp_reg        <= '0;
            rx_cnt_reg     <= '0;
            err_op_reg     <= 1'b0;
            err_nolast_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            exp_reg        <= exp_next;
            rx_cnt_reg     <= rx_cnt_next;
            err_op_reg     <= err_op_next;
            err_nolast_reg <= err_nolast_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        exp_next        = exp_reg;
        rx_cnt_next     = rx_cnt_reg;
        err_op_next     = err_op_reg;
        err_nolast_next = err_nolast_reg;

        case (state_reg)
            RX_IDLE: begin
                if (START) begin
                    exp_next        = EXPECT_CNT;
                    rx_cnt_next     = '0;
                    err_op_next     = 1'b0;
                    err_nolast_next = 1'b0;
                    state_next      = (EXPECT_CNT == '0) ? RX_FINISH : RX_COLLECT;
                end
            end
            RX_COLLECT: begin
                if (beat_hs) begin
                    // A missing TLAST outranks a bad opcode.
                    if (!AXIS_S_TLAST) begin
                        err_nolast_next = 1'b1;
                    end else if (beat_op != RES_OP) begin
                        err_op_next = 1'b1;
                    end else begin
                        rx_cnt_next = rx_cnt_reg + CNTW'(1);
                    end
                end
                if (rx_cnt_next == exp_reg) begin
                    state_next = RX_DRAIN;
                end
            end
            RX_DRAIN: begin
                // Move on at the edge that empties the FIFO so DONE follows it directly.
                if (fifo_empty || (fifo_pop && fifo_count == (FIFO_AW+1)'(1))) begin
                    state_next = RX_FINISH;
                end
            end
            RX_FINISH: begin
                state_next = RX_IDLE;
            end
            default: begin
                state_next = RX_IDLE;
            end
        endcase
    end

    assign RX_CNT     = rx_cnt_reg;
    assign BUSY       = (state_reg == RX_COLLECT) || (state_reg == RX_DRAIN);
    assign DONE       = (state_reg == RX_FINISH);
    assign ERR_OP     = err_op_reg;
    assign ERR_NOLAST = err_nolast_reg;

endmodule
